// File: rtl/serial_rx.sv
// serial_rx: 8N1 serial receiver with 16x oversampling.
//
// The line is synchronised through two flops, then sampled only on the
// oversample tick produced by a 26-bit phase accumulator. Each byte is
// sampled mid-bit (8 ticks into the start bit, then every 16 ticks).
// A received byte is handed over through a level ready/ack handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous reset, active low
//   rxIn       asynchronous serial line, idle high
//   ack        consumer took the byte; clears dataReady
//   data       last good byte, held until the next good frame
//   dataReady  level: a good byte is waiting in data
//   frameErr   one-clk pulse: stop bit sampled low
//   overrun    one-clk pulse: good frame landed on an unacknowledged byte
//   busy       receiver is not idle
module serial_rx #(
    parameter logic [25:0] INCR = 26'd412320
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxIn,
    input  logic       ack,
    output logic [7:0] data,
    output logic       dataReady,
    output logic       frameErr,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [25:0] accum_q;
    logic [26:0] sum;
    logic        tick;
    logic        rx1_q, rx2_q;
    logic        rxS;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    // Frame-end events from the FSM; the handshake outputs update one
    // clk later from these, keeping every output a plain register.
    logic        good_q, good_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        ferr_q, ovr_q;

    assign sum  = {1'b0, accum_q} + {1'b0, INCR};
    assign tick = sum[26];
    assign rxS  = rx2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        good_d  = 1'b0;
        err_d   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxS) begin
                        state_d = START;
                        cnt_d   = 4'd0;
                    end
                end
                START: begin
                    if (cnt_q == 4'd7) begin
                        // Still low at mid start bit: real frame. Otherwise a glitch.
                        if (!rxS) begin
                            state_d = DATA;
                            cnt_d   = 4'd0;
                            idx_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 4'd1;  // wraps 15 -> 0 at each sample
                    if (cnt_q == 4'd15) begin
                        shift_d = {rxS, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = STOP;
                    end
                end
                STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // Leave at mid stop so a back-to-back start edge is caught.
                        state_d = IDLE;
                        good_d  = rxS;
                        err_d   = !rxS;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        rdy_d  = rdy_q;
        if (good_q) begin
            // A new byte wins over a simultaneous ack.
            data_d = shift_q;
            rdy_d  = 1'b1;
        end else if (ack) begin
            rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            accum_q <= '0;
            rx1_q   <= 1'b1;
            rx2_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            good_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            accum_q <= sum[25:0];
            rx1_q   <= rxIn;
            rx2_q   <= rx1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            good_q  <= good_d;
            err_q   <= err_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= err_q;
            ovr_q   <= good_q & rdy_q & ~ack;
        end
    end

    assign data      = data_q;
    assign dataReady = rdy_q;
    assign frameErr  = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule
